// File: rtl/fetch_redirect_arb.sv
// Front-end redirect arbiter: sequences commit flushes and decode redirects into fetch,
// holding the winner while fetch is blocked and squashing wrong-path decode redirects.
module fetch_redirect_arb #(
    parameter int EPOCH_BITS    = 3,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_valid,
    input  logic [31:0]           flush_pc,
    input  logic                  dec_redir_valid,
    input  logic [31:0]           dec_redir_pc,
    input  logic [1:0]            dec_redir_kind,
    input  logic                  fetch_accept,
    output logic                  redir_valid,
    output logic [31:0]           redir_pc,
    output logic [1:0]            redir_src,
    output logic [1:0]            redir_kind,
    output logic                  fetch_kill,
    output logic [EPOCH_BITS-1:0] epoch,
    output logic                  squashing,
    output logic [1:0]            dbg_state
);

    // Handshake: redir_valid/redir_pc/redir_src/redir_kind are offered to fetch and the
    // redirect is consumed (issued) in any cycle where redir_valid & fetch_accept.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND_LOW  = 2'd1,
        PEND_HIGH = 2'd2,
        SQUASH    = 2'd3
    } state_t;

    localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

    state_t                  state;
    logic [31:0]             held_pc;
    logic [1:0]              held_kind;
    logic [3:0]              sq_cnt;
    logic [EPOCH_BITS-1:0]   epoch_q;

    logic                    pend_hi;
    logic                    pend_lo;
    logic                    dec_eff;
    logic [1:0]              dec_kind_norm;
    logic                    issue;
    logic                    flush_issue;

    assign pend_hi       = (state == PEND_HIGH);
    assign pend_lo       = (state == PEND_LOW);
    assign squashing     = (sq_cnt != 4'd0);
    // A decode redirect arriving behind any pending redirect is younger, hence wrong-path.
    assign dec_eff       = dec_redir_valid & ~flush_valid & ~squashing & ~pend_hi & ~pend_lo;
    assign dec_kind_norm = (dec_redir_kind == 2'd3) ? 2'd0 : dec_redir_kind;
    assign fetch_kill    = flush_valid | dec_eff | pend_lo | pend_hi;
    assign epoch         = epoch_q;
    assign dbg_state     = state;

    always_comb begin
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        redir_src   = 2'd0;
        redir_kind  = 2'd0;
        if (pend_hi) begin
            redir_valid = 1'b1;
            redir_pc    = held_pc;
            redir_src   = 2'd1;
        end else if (flush_valid) begin
            redir_valid = 1'b1;
            redir_pc    = flush_pc;
            redir_src   = 2'd1;
        end else if (pend_lo) begin
            redir_valid = 1'b1;
            redir_pc    = held_pc;
            redir_src   = 2'd2;
            redir_kind  = held_kind;
        end else if (dec_eff) begin
            redir_valid = 1'b1;
            redir_pc    = dec_redir_pc;
            redir_src   = 2'd2;
            redir_kind  = dec_kind_norm;
        end
    end

    assign issue       = redir_valid & fetch_accept;
    assign flush_issue = issue & (redir_src == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held_pc   <= 32'd0;
            held_kind <= 2'd0;
            sq_cnt    <= 4'd0;
            epoch_q   <= '0;
        end else begin
            if (issue) begin
                epoch_q <= epoch_q + EPOCH_BITS'(1);
            end
            if (flush_issue) begin
                state  <= (SQUASH_CYCLES > 0) ? SQUASH : IDLE;
                sq_cnt <= SQ_LOAD;
            end else if (pend_hi) begin
                // Commit never sends a second flush before the held one drains.
                state <= PEND_HIGH;
            end else if (flush_valid) begin
                state     <= PEND_HIGH;
                held_pc   <= flush_pc;
                held_kind <= 2'd0;
            end else if (pend_lo) begin
                if (issue) begin
                    state <= IDLE;
                end
            end else if (dec_eff) begin
                if (issue) begin
                    state <= IDLE;
                end else begin
                    state     <= PEND_LOW;
                    held_pc   <= dec_redir_pc;
                    held_kind <= dec_kind_norm;
                end
            end else if (state == SQUASH) begin
                sq_cnt <= sq_cnt - 4'd1;
                if (sq_cnt <= 4'd1) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_arb.sv
// Directed bench for fetch_redirect_arb: each scenario task drives vectors at the
// falling edge and checks hand-computed expectations before the next rising edge.
module tb_fetch_redirect_arb;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_SQ   = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        dec_redir_valid;
    logic [31:0] dec_redir_pc;
    logic [1:0]  dec_redir_kind;
    logic        fetch_accept;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [1:0]  redir_src;
    logic [1:0]  redir_kind;
    logic        fetch_kill;
    logic [2:0]  epoch;
    logic        squashing;
    logic [1:0]  dbg_state;

    int          errors;
    int          checks;
    logic [2:0]  exp_epoch;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    fetch_redirect_arb #(.EPOCH_BITS(3), .SQUASH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .dec_redir_valid(dec_redir_valid), .dec_redir_pc(dec_redir_pc),
        .dec_redir_kind(dec_redir_kind), .fetch_accept(fetch_accept),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_src(redir_src),
        .redir_kind(redir_kind), .fetch_kill(fetch_kill), .epoch(epoch),
        .squashing(squashing), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply one cycle of inputs at the falling edge, settle, return for checks.
    task automatic drive(input logic fv, input logic [31:0] fpc, input logic dv,
                         input logic [31:0] dpc, input logic [1:0] dk, input logic acc);
        @(negedge clk);
        flush_valid     = fv;
        flush_pc        = fpc;
        dec_redir_valid = dv;
        dec_redir_pc    = dpc;
        dec_redir_kind  = dk;
        fetch_accept    = acc;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_valid = 0; flush_pc = 0; dec_redir_valid = 0;
        dec_redir_pc = 0; dec_redir_kind = 0; fetch_accept = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_epoch = 3'd0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({redir_valid, redir_pc, redir_src, redir_kind, fetch_kill, squashing} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b pc=%h src=%0d kind=%0d kill=%0b sq=%0b, need all 0",
                     redir_valid, redir_pc, redir_src, redir_kind, fetch_kill, squashing);
        end
        checks++;
        if (epoch !== 3'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got epoch=%0d state=%0d, need 0/0", epoch, dbg_state);
        end
    endtask

    task automatic test_flush_accept();
        drive(1'b1, 32'h1000, 1'b0, 32'd0, 2'd0, 1'b1);
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h1000 || redir_src !== 2'd1 || redir_kind !== 2'd0 || fetch_kill !== 1'b1) begin
            errors++;
            $display("FAIL flush_bypass: got valid=%0b pc=%h src=%0d kind=%0d kill=%0b, need 1/1000/1/0/1",
                     redir_valid, redir_pc, redir_src, redir_kind, fetch_kill);
        end
        exp_epoch++;
        idle(1);
        checks++;
        if (epoch !== exp_epoch || squashing !== 1'b1 || redir_valid !== 1'b0 || dbg_state !== S_SQ) begin
            errors++;
            $display("FAIL flush_t1: got epoch=%0d sq=%0b valid=%0b state=%0d, need %0d/1/0/3",
                     epoch, squashing, redir_valid, dbg_state, exp_epoch);
        end
        idle(1);
        checks++;
        if (squashing !== 1'b1) begin
            errors++;
            $display("FAIL flush_t2_squash: got %0b, need 1", squashing);
        end
        idle(1);
        checks++;
        if (squashing !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL flush_t3_squash: got sq=%0b state=%0d, need 0/0", squashing, dbg_state);
        end
    endtask

    task automatic test_blocked_decode();
        drive(1'b0, 32'd0, 1'b1, 32'h2000, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (redir_valid !== 1'b1 || redir_pc !== 32'h2000 || redir_src !== 2'd2 || redir_kind !== 2'd2 || fetch_kill !== 1'b1) begin
                errors++;
                $display("FAIL blocked_hold[%0d]: got valid=%0b pc=%h src=%0d kind=%0d kill=%0b, need 1/2000/2/2/1",
                         i, redir_valid, redir_pc, redir_src, redir_kind, fetch_kill);
            end
            if (i < 2) idle(1);
        end
        checks++;
        if (dbg_state !== S_LOW || epoch !== exp_epoch) begin
            errors++;
            $display("FAIL blocked_state: got state=%0d epoch=%0d, need 1/%0d", dbg_state, epoch, exp_epoch);
        end
        drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1);
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h2000) begin
            errors++;
            $display("FAIL blocked_issue: got valid=%0b pc=%h, need 1/2000", redir_valid, redir_pc);
        end
        exp_epoch++;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1);
        checks++;
        if (redir_valid !== 1'b0 || dbg_state !== S_IDLE || epoch !== exp_epoch || fetch_kill !== 1'b0 || squashing !== 1'b0) begin
            errors++;
            $display("FAIL blocked_after: got valid=%0b state=%0d epoch=%0d kill=%0b sq=%0b, need 0/0/%0d/0/0",
                     redir_valid, dbg_state, epoch, fetch_kill, squashing, exp_epoch);
        end
    endtask

    task automatic test_upgrade();
        drive(1'b0, 32'd0, 1'b1, 32'h2000, 2'd1, 1'b0);
        drive(1'b1, 32'h3000, 1'b0, 32'd0, 2'd0, 1'b0);
        checks++;
        if (redir_pc !== 32'h3000 || redir_src !== 2'd1 || redir_kind !== 2'd0) begin
            errors++;
            $display("FAIL upgrade_present: got pc=%h src=%0d kind=%0d, need 3000/1/0", redir_pc, redir_src, redir_kind);
        end
        idle(1);
        checks++;
        if (dbg_state !== S_HIGH || redir_pc !== 32'h3000 || redir_valid !== 1'b1) begin
            errors++;
            $display("FAIL upgrade_held: got state=%0d pc=%h valid=%0b, need 2/3000/1", dbg_state, redir_pc, redir_valid);
        end
        // A second flush while high is pending must not replace the held pc.
        drive(1'b1, 32'h7777, 1'b0, 32'd0, 2'd0, 1'b1);
        checks++;
        if (redir_pc !== 32'h3000) begin
            errors++;
            $display("FAIL upgrade_keep_pc: got %h, need 3000", redir_pc);
        end
        exp_epoch++;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1);
        checks++;
        if (epoch !== exp_epoch || redir_valid !== 1'b0 || dbg_state !== S_SQ) begin
            errors++;
            $display("FAIL upgrade_single_issue: got epoch=%0d valid=%0b state=%0d, need %0d/0/3",
                     epoch, redir_valid, dbg_state, exp_epoch);
        end
        idle(2);
    endtask

    task automatic test_squash();
        drive(1'b1, 32'h1100, 1'b0, 32'd0, 2'd0, 1'b1);
        exp_epoch++;
        drive(1'b0, 32'd0, 1'b1, 32'h2200, 2'd0, 1'b1);
        checks++;
        if (redir_valid !== 1'b0 || fetch_kill !== 1'b0) begin
            errors++;
            $display("FAIL squash_ignore: got valid=%0b kill=%0b, need 0/0", redir_valid, fetch_kill);
        end
        idle(1);
        drive(1'b0, 32'd0, 1'b1, 32'h2200, 2'd3, 1'b1);
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h2200 || redir_src !== 2'd2 || redir_kind !== 2'd0) begin
            errors++;
            $display("FAIL squash_honour: got valid=%0b pc=%h src=%0d kind=%0d, need 1/2200/2/0",
                     redir_valid, redir_pc, redir_src, redir_kind);
        end
        exp_epoch++;
        idle(1);
        checks++;
        if (epoch !== exp_epoch || squashing !== 1'b0) begin
            errors++;
            $display("FAIL squash_epoch: got epoch=%0d sq=%0b, need %0d/0", epoch, squashing, exp_epoch);
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        drive(1'b1, 32'h4000, 1'b1, 32'h5000, 2'd0, 1'b1);
        checks++;
        if (redir_pc !== 32'h4000 || redir_src !== 2'd1) begin
            errors++;
            $display("FAIL simul_flush_wins: got pc=%h src=%0d, need 4000/1", redir_pc, redir_src);
        end
        exp_epoch++;
        idle(3);
        checks++;
        if (redir_valid !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL simul_dec_dropped: got valid=%0b state=%0d, need 0/0", redir_valid, dbg_state);
        end
        for (int i = 0; i < 7; i++) exp_q.push_back(32'h6000 + 32'(i * 4));
        for (int i = 0; i < 7; i++) begin
            exp_pc = exp_q.pop_front();
            drive(1'b0, 32'd0, 1'b1, exp_pc, 2'(i % 3), 1'b1);
            checks++;
            if (redir_valid !== 1'b1 || redir_pc !== exp_pc || redir_kind !== 2'(i % 3)) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: got valid=%0b pc=%h kind=%0d, need 1/%h/%0d",
                         i, redir_valid, redir_pc, redir_kind, exp_pc, i % 3);
            end
            exp_epoch++;
        end
        idle(1);
        checks++;
        if (epoch !== 3'd0 || exp_epoch !== 3'd0) begin
            errors++;
            $display("FAIL epoch_wrap: got %0d, need 0", epoch);
        end
    endtask

    task automatic test_reset_pending();
        drive(1'b1, 32'h8000, 1'b0, 32'd0, 2'd0, 1'b0);
        idle(1);
        checks++;
        if (dbg_state !== S_HIGH || redir_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstpend_setup: got state=%0d valid=%0b, need 2/1", dbg_state, redir_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (redir_valid !== 1'b0 || redir_pc !== 32'd0 || redir_src !== 2'd0 || fetch_kill !== 1'b0 || epoch !== 3'd0 || squashing !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL rstpend_async: got valid=%0b pc=%h src=%0d kill=%0b epoch=%0d sq=%0b state=%0d, need all 0",
                     redir_valid, redir_pc, redir_src, fetch_kill, epoch, squashing, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1);
            checks++;
            if (redir_valid !== 1'b0 || epoch !== 3'd0) begin
                errors++;
                $display("FAIL rstpend_after[%0d]: got valid=%0b epoch=%0d, need 0/0", i, redir_valid, epoch);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_flush_accept();
        test_blocked_decode();
        test_upgrade();
        test_squash();
        test_back_to_back_wrap();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fetch_redirect_arb.md
# fetch_redirect_arb

Arbitrates and sequences front-end redirect requests into the instruction-fetch stage. Sources are the commit-side flush, which is oldest and highest priority, and decode-side redirects: mispredict, invalid instruction and return. When the fetch stage cannot accept a redirect because the ICache is blocked on a miss, the block holds the winning redirect until it can. It also maintains a fetch epoch and a post-flush squash window so that wrong-path decode redirects are discarded.

## Interface
Parameters:
- EPOCH_BITS, 3, width of the fetch epoch counter.
- SQUASH_CYCLES, 2, cycles after an issued flush during which decode redirects are ignored; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_valid  in  1  commit-side flush request, single-cycle pulse.
- flush_pc  in  32  flush target address.
- dec_redir_valid  in  1  decode-side redirect request, single-cycle pulse.
- dec_redir_pc  in  32  decode redirect target.
- dec_redir_kind  in  2  0 mispredict, 1 invalid instruction, 2 return, 3 reserved (treated as 0).
- fetch_accept  in  1  fetch stage can apply a redirect this cycle (ICache hit / unblocked).
- redir_valid  out  1  redirect presented to fetch.
- redir_pc  out  32  redirect target.
- redir_src  out  2  0 none, 1 flush, 2 decode.
- redir_kind  out  2  kind of the presented decode redirect; 0 when redir_src is flush.
- fetch_kill  out  1  fetch must drop its current output packet this cycle.
- epoch  out  EPOCH_BITS  incremented on every issued redirect.
- squashing  out  1  squash window active.

## Operation
States:
- IDLE: no redirect pending.
- PEND_LOW: decode redirect held.
- PEND_HIGH: flush held.
- SQUASH: post-flush window with nothing pending.

Effective decode request:
- dec_eff = dec_redir_valid & ~flush_valid & ~squashing & (state != PEND_HIGH) & (state != PEND_LOW).
- A decode request arriving while any redirect is pending is dropped, because it is younger and therefore wrong-path.

Candidate selection, in priority order:
- Pending HIGH.
- New flush.
- Pending LOW.
- dec_eff.

Presentation and issue:
- redir_valid = candidate exists; redir_pc, redir_src and redir_kind come from that candidate.
- New requests bypass combinationally, so redir_valid can assert in the same cycle as the request.
- Issue occurs when redir_valid & fetch_accept.

Transitions:
- From IDLE or SQUASH: a flush that is not issued goes to PEND_HIGH and latches flush_pc. A dec_eff that is not issued goes to PEND_LOW and latches pc and kind.
- From PEND_LOW: a new flush overrides the held decode redirect. If the flush issues the same cycle, go to SQUASH; otherwise go to PEND_HIGH with flush_pc latched.
- From PEND_HIGH: a new flush_valid is ignored and the held pc is kept, because commit guarantees no second flush before drain.
- On flush issue: go to SQUASH if SQUASH_CYCLES > 0, else IDLE. The squash counter loads SQUASH_CYCLES and decrements once per cycle in SQUASH; at 0, return to IDLE.
- On decode issue: go to IDLE. The squash counter is unaffected.
- A flush during SQUASH is accepted like a flush from IDLE. If it issues, the counter reloads.

Other outputs:
- squashing = (squash counter != 0).
- fetch_kill = flush_valid | dec_eff | (state == PEND_LOW) | (state == PEND_HIGH).
- epoch = epoch + 1, mod 2^EPOCH_BITS, on each issue; it wraps from max to 0.

## Timing
- Reset values: state IDLE, epoch 0, squash counter 0, held pc 0, held kind 0. Outputs redir_valid 0, redir_pc 0, redir_src 0, redir_kind 0, fetch_kill 0, squashing 0.
- Reset asserted mid-pending discards the held redirect with no issue.
- Latency: 0 cycles from request to redir_valid. A held redirect issues in the first cycle fetch_accept=1.
- redir_valid stays high with stable pc, src and kind until issue, except when a flush upgrade changes them.
- epoch updates at the clock edge of issue; the new value is visible the next cycle.
- Squash window: flush issued at cycle T causes squashing=1 during T+1..T+SQUASH_CYCLES and 0 at T+SQUASH_CYCLES+1.
- Simultaneous flush and decode requests: flush wins and the decode request is dropped, not queued.

## Test plan
- Flush and accept in the same cycle: flush_valid=1, flush_pc=0x1000, fetch_accept=1 at T. Required: redir_valid=1, redir_pc=0x1000, redir_src=1 at T; epoch 0→1; squashing=1 at T+1 and T+2, 0 at T+3.
- Blocked decode redirect: dec_redir_valid with pc=0x2000, kind=2 while fetch_accept=0 for 3 cycles. Required: redir_valid held with 0x2000, kind 2, fetch_kill=1 throughout; issue on the cycle fetch_accept=1; state returns to IDLE.
- Upgrade: decode 0x2000 held, flush 0x3000 arrives with fetch_accept=0. Required: redir_pc=0x3000, src=1; after accept, one epoch increment only.
- Squash: decode redirect 1 cycle after an issued flush. Required: ignored, redir_valid=0, fetch_kill=0. The same request at T+3 is honoured.
- Simultaneous requests plus wrap: flush 0x4000 and decode 0x5000 in the same cycle. Required: only 0x4000 issued. Repeat 8 issues with EPOCH_BITS=3; epoch returns to 0.
- Reset while in PEND_HIGH: all outputs return to reset values, with no redir_valid after deassert.
